tea_decrypt_iter: RTL and testbench

Iterative, multi-cycle TEA decryption core. It is the receive-side counterpart of the team's combinational TEA encryptor. It executes one full TEA round per clock instead of unrolling every round into one combinational cloud. It loads its 128-bit key through a 64-bit two-beat write port and accepts and returns 64-bit blocks over valid/ready handshakes.

---
 rtl/tea_pkg.sv | 23 ++
 rtl/tea_dec_round.sv | 20 ++
 rtl/tea_decrypt_iter.sv | 124 ++++++++++++
 tb/tb_tea_decrypt_iter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared TEA types, key-schedule constant and the round mixing function.
// Used by both the iterative decryptor and the encrypt-side round.
package tea_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [63:0]  block_t;
  typedef logic [127:0] key_t;

  localparam word_t DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Mixing term shared by encrypt and decrypt; shifts are logical on unsigned words.
  function automatic word_t tea_f(input word_t v, input word_t ka, input word_t kb,
                                  input word_t sum);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One combinational TEA decryption round; v1 is updated first and feeds the v0 step.
module tea_dec_round
  import tea_pkg::*;
(
  input  word_t v0_i,
  input  word_t v1_i,
  input  key_t  key_i,
  input  word_t sum_i,
  output word_t v0_o,
  output word_t v1_o
);

  word_t k0, k1, k2, k3;

  assign {k0, k1, k2, k3} = key_i;

  assign v1_o = v1_i - tea_f(v0_i, k2, k3, sum_i);
  assign v0_o = v0_i - tea_f(v1_o, k0, k1, sum_i);

endmodule

// File: rtl/tea_decrypt_iter.sv
// Iterative TEA decryptor: one round per clock, two-beat key load,
// valid/ready block interfaces on both sides.
module tea_decrypt_iter #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = tea_pkg::DELTA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        key_wr,
  output logic        key_valid,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  import tea_pkg::*;

  localparam logic [63:0] SUM_FULL  = 64'(ROUNDS) * 64'(DELTA);
  localparam word_t       SUM_INIT  = SUM_FULL[31:0];
  localparam logic [7:0]  RCNT_INIT = 8'(ROUNDS - 1);

  state_e     state_q, state_d;
  key_t       key_q, key_d;
  logic       key_pending_q, key_pending_d;
  logic       key_valid_q, key_valid_d;
  word_t      v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [7:0] rcnt_q, rcnt_d;
  word_t      v0_rnd, v1_rnd;
  logic       accept;

  tea_dec_round u_round (
    .v0_i  (v0_q),
    .v1_i  (v1_q),
    .key_i (key_q),
    .sum_i (sum_q),
    .v0_o  (v0_rnd),
    .v1_o  (v1_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = RUN;
      RUN:     if (rcnt_q == '0)  state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // A pending high half or a fresh key beat blocks acceptance so a block never sees a torn key.
  always_comb begin
    in_ready  = (state_q == IDLE) && key_valid_q && !key_pending_q && !key_wr;
    accept    = in_valid && in_ready;
    out_valid = (state_q == DONE);
    out_data  = out_valid ? {v0_q, v1_q} : '0;
    key_valid = key_valid_q;
  end

  always_comb begin
    key_d         = key_q;
    key_pending_d = key_pending_q;
    key_valid_d   = key_valid_q;
    v0_d          = v0_q;
    v1_d          = v1_q;
    sum_d         = sum_q;
    rcnt_d        = rcnt_q;
    case (state_q)
      IDLE: begin
        if (key_wr) begin
          key_d[127:64] = key_in;
          key_pending_d = 1'b1;
          key_valid_d   = 1'b0;
        end else if (key_pending_q) begin
          key_d[63:0]   = key_in;
          key_pending_d = 1'b0;
          key_valid_d   = 1'b1;
        end
        if (accept) begin
          v0_d   = in_data[63:32];
          v1_d   = in_data[31:0];
          sum_d  = SUM_INIT;
          rcnt_d = RCNT_INIT;
        end
      end
      RUN: begin
        v0_d  = v0_rnd;
        v1_d  = v1_rnd;
        sum_d = sum_q - DELTA;
        if (rcnt_q != '0) rcnt_d = rcnt_q - 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q         <= '0;
      key_pending_q <= 1'b0;
      key_valid_q   <= 1'b0;
      v0_q          <= '0;
      v1_q          <= '0;
      sum_q         <= '0;
      rcnt_q        <= '0;
    end else begin
      key_q         <= key_d;
      key_pending_q <= key_pending_d;
      key_valid_q   <= key_valid_d;
      v0_q          <= v0_d;
      v1_q          <= v1_d;
      sum_q         <= sum_d;
      rcnt_q        <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_tea_decrypt_iter.sv
// Scoreboard bench for tea_decrypt_iter: directed vectors plus encrypt-model round trips.
module tb_tea_decrypt_iter;
  import tea_pkg::*;

  localparam int ROUNDS = 32;
  localparam logic [63:0] CT_ZERO = 64'h41EA3A0A_94BAA940;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key_in = '0;
  logic        key_wr = 1'b0;
  logic        key_valid;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  int          rise_q[$];

  tea_decrypt_iter #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_wr(key_wr), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // Reference encryptor, written independently of the decrypt datapath.
  function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k);
    logic [31:0] y, z, s;
    y = p[63:32]; z = p[31:0]; s = '0;
    for (int r = 0; r < ROUNDS; r++) begin
      s = s + 32'h9E3779B9;
      y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  // Monitor: checks latency on each out_valid rise and data on each handshake.
  initial begin
    bit ovp;
    ovp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) ovp = 1'b0;
      else begin
        if (out_valid && !ovp) begin
          if (rise_q.size() == 0) fail("unexpected_out_valid");
          else chk("latency_cycle", 64'(cyc), 64'(rise_q.pop_front()));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail("unexpected_output");
          else chk("out_data", out_data, exp_q.pop_front());
        end
        ovp = out_valid;
      end
    end
  end

  task automatic load_key(input logic [127:0] k);
    key_wr = 1'b1; key_in = k[127:64];
    @(posedge clk); #1;
    key_wr = 1'b0; key_in = k[63:0];
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [63:0] c, input logic [63:0] e, input bit track);
    int n;
    n = 0;
    in_data = c; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 200) begin
        fail("in_ready_timeout");
        in_valid = 1'b0;
        return;
      end
    end
    if (track) begin
      exp_q.push_back(e);
      rise_q.push_back(cyc + 1 + ROUNDS);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) return;
      if (++n > 200) begin
        fail("out_valid_timeout");
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
      if (++n > 500) begin
        fail("drain_timeout");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] k;
    logic [63:0]  p;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_valid", 64'(key_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Key gating: no key yet, then high half only
    in_valid = 1'b1; in_data = CT_ZERO;
    repeat (4) begin
      @(negedge clk);
      chk("nokey_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    key_wr = 1'b1; key_in = '0;
    @(posedge clk); #1;
    key_wr = 1'b0; key_in = '0;
    @(negedge clk);
    chk("half_key_valid", 64'(key_valid), 64'd0);
    chk("half_in_ready",  64'(in_ready),  64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_key_valid", 64'(key_valid), 64'd1);
    chk("full_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    // Basic decrypt with all-zero key
    out_ready = 1'b1;
    send(CT_ZERO, 64'd0, 1'b1);
    wait_ov();
    chk("final_sum", 64'(dut.sum_q), 64'd0);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(CT_ZERO, 64'd0, 1'b1);
    wait_ov();
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_data",  out_data,       64'd0);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_bp_out_valid", 64'(out_valid), 64'd0);
    chk("post_bp_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    // Key write while running is ignored
    out_ready = 1'b1;
    send(CT_ZERO, 64'd0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    key_wr = 1'b1; key_in = '1;
    repeat (2) @(posedge clk);
    #1;
    key_wr = 1'b0; key_in = '0;
    wait_ov();
    chk("run_key_valid", 64'(key_valid), 64'd1);
    drain();

    // Reset mid-operation
    send(CT_ZERO, 64'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data",  out_data,       64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    chk("midrst_key_valid", 64'(key_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_key_valid", 64'(key_valid), 64'd0);
      chk("postrst_in_ready",  64'(in_ready),  64'd0);
    end
    @(posedge clk); #1;
    load_key('0);
    send(CT_ZERO, 64'd0, 1'b1);
    drain();

    // Random round trips, back-to-back blocks per key
    for (int g = 0; g < 10; g++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k);
      for (int b = 0; b < 20; b++) begin
        p = {$urandom, $urandom};
        send(tea_enc(p, k), p, 1'b1);
      end
      drain();
    end

    if (rise_q.size() != 0) fail("pending_latency_entries");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
